// File: rtl/cb_rd_seq.sv
// Covariance-bank port A read sequencer: issues len consecutive reads and
// returns select/beat/parity aligned with the bank's read data.
module cb_rd_seq #(
  parameter int CB_AW           = 10,
  parameter int SEQ_CNT_DW      = 10,
  parameter int CB_DOUTA_SEL_DW = 5,
  parameter int RD_LAT          = 2
) (
  input  logic                       clk,
  input  logic                       sys_rst,
  input  logic                       start,
  input  logic [CB_DOUTA_SEL_DW-1:0] cmd_sel,
  input  logic [CB_AW-1:0]           cmd_base,
  input  logic [SEQ_CNT_DW-1:0]      cmd_len,
  input  logic                       cmd_dec,
  input  logic                       cmd_l_k_0,
  input  logic                       stall,
  output logic                       ready,
  output logic                       CB_ena,
  output logic [CB_AW-1:0]           CB_addra,
  output logic [CB_DOUTA_SEL_DW-1:0] CB_douta_sel,
  output logic [SEQ_CNT_DW-1:0]      seq_cnt_dout_sel,
  output logic                       l_k_0,
  output logic                       done
);

  // IDLE: accept cmd | DONE0: zero-length pulse | ISSUE: reads | DRAIN: wait for last beat
  typedef enum logic [1:0] {IDLE, DONE0, ISSUE, DRAIN} state_t;

  typedef struct packed {
    logic                       last;
    logic                       lk;
    logic [SEQ_CNT_DW-1:0]      cnt;
    logic [CB_DOUTA_SEL_DW-1:0] sel;
  } beat_t;

  state_t                     state_q, state_d;
  logic [SEQ_CNT_DW-1:0]      cnt_q, cnt_d;
  logic [SEQ_CNT_DW-1:0]      len_q, len_d;
  logic [CB_DOUTA_SEL_DW-1:0] sel_q, sel_d;
  logic [CB_AW-1:0]           base_q, base_d;
  logic                       dec_q, dec_d;
  logic                       lk_q, lk_d;
  logic                       ena_q, ena_d;
  logic [CB_AW-1:0]           addr_q, addr_d;
  logic                       ready_q, ready_d;
  logic                       done_q, done_d;
  beat_t                      push_d;
  logic                       last_beat;
  logic [CB_AW-1:0]           cnt_a;

  // stage 0 is registered alongside CB_ena; stage RD_LAT lines up with CB_douta
  beat_t stage_q [RD_LAT+1];

  assign cnt_a     = CB_AW'(cnt_q);
  assign last_beat = (cnt_q == len_q - SEQ_CNT_DW'(1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    sel_d   = sel_q;
    base_d  = base_q;
    dec_d   = dec_q;
    lk_d    = lk_q;
    ena_d   = 1'b0;
    addr_d  = addr_q;
    push_d  = '0;
    case (state_q)
      IDLE: begin
        if (start) begin
          sel_d  = cmd_sel;
          base_d = cmd_base;
          dec_d  = cmd_dec;
          lk_d   = cmd_l_k_0;
          len_d  = cmd_len;
          cnt_d  = '0;
          if (cmd_len == '0) begin
            state_d = DONE0;
          end else begin
            // beat 0 leaves on the accepting edge so reads start the next cycle
            ena_d       = 1'b1;
            addr_d      = cmd_base;
            push_d.last = (cmd_len == SEQ_CNT_DW'(1));
            push_d.lk   = cmd_l_k_0;
            push_d.cnt  = '0;
            push_d.sel  = cmd_sel;
            cnt_d       = SEQ_CNT_DW'(1);
            state_d     = (cmd_len == SEQ_CNT_DW'(1)) ? DRAIN : ISSUE;
          end
        end
      end
      DONE0: state_d = IDLE;
      ISSUE: begin
        if (!stall) begin
          ena_d       = 1'b1;
          addr_d      = dec_q ? (base_q - cnt_a) : (base_q + cnt_a);
          push_d.last = last_beat;
          push_d.lk   = lk_q;
          push_d.cnt  = cnt_q;
          push_d.sel  = sel_q;
          cnt_d       = cnt_q + SEQ_CNT_DW'(1);
          if (last_beat) state_d = DRAIN;
        end
      end
      DRAIN: if (stage_q[RD_LAT].last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == IDLE);
    done_d  = (state_d == DONE0) || stage_q[RD_LAT-1].last;
  end

  always_ff @(posedge clk) begin
    if (sys_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      len_q   <= '0;
      sel_q   <= '0;
      base_q  <= '0;
      dec_q   <= 1'b0;
      lk_q    <= 1'b0;
      ena_q   <= 1'b0;
      addr_q  <= '0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      for (int i = 0; i <= RD_LAT; i++) stage_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      sel_q   <= sel_d;
      base_q  <= base_d;
      dec_q   <= dec_d;
      lk_q    <= lk_d;
      ena_q   <= ena_d;
      addr_q  <= addr_d;
      ready_q <= ready_d;
      done_q  <= done_d;
      stage_q[0] <= push_d;
      for (int i = 1; i <= RD_LAT; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign ready            = ready_q;
  assign CB_ena           = ena_q;
  assign CB_addra         = addr_q;
  assign CB_douta_sel     = stage_q[RD_LAT].sel;
  assign seq_cnt_dout_sel = stage_q[RD_LAT].cnt;
  assign l_k_0            = stage_q[RD_LAT].lk;
  assign done             = done_q;

endmodule

// File: tb/tb_cb_rd_seq.sv
// Bench for cb_rd_seq: per-cycle traces compared against a beat-schedule model.
module tb_cb_rd_seq;
  localparam int AW = 10, CW = 10, SW = 5, RD = 2, N = 80;
  localparam int VW = 1 + AW + SW + CW + 3;

  logic          clk = 1'b0;
  logic          sys_rst = 1'b1, start = 1'b0, cmd_dec = 1'b0, cmd_l_k_0 = 1'b0, stall = 1'b0;
  logic [SW-1:0] cmd_sel = '0;
  logic [AW-1:0] cmd_base = '0;
  logic [CW-1:0] cmd_len = '0;
  logic          ready, CB_ena, l_k_0, done;
  logic [SW-1:0] CB_douta_sel;
  logic [AW-1:0] CB_addra;
  logic [CW-1:0] seq_cnt_dout_sel;

  // vector layout: {ena, addr, sel, cnt, l_k_0, done, ready}
  logic [VW-1:0] obs_vec [N];
  logic [VW-1:0] exp_vec [N];
  bit stall_in [N];   // stall_in[t]: issue slot of cycle t is stalled
  bit start_pat [N];
  bit rst_pat [N];
  int checks = 0, errors = 0;
  logic [AW-1:0] model_addr = '0;

  cb_rd_seq #(.CB_AW(AW), .SEQ_CNT_DW(CW), .CB_DOUTA_SEL_DW(SW), .RD_LAT(RD)) dut (
    .clk(clk), .sys_rst(sys_rst), .start(start), .cmd_sel(cmd_sel), .cmd_base(cmd_base),
    .cmd_len(cmd_len), .cmd_dec(cmd_dec), .cmd_l_k_0(cmd_l_k_0), .stall(stall),
    .ready(ready), .CB_ena(CB_ena), .CB_addra(CB_addra), .CB_douta_sel(CB_douta_sel),
    .seq_cnt_dout_sel(seq_cnt_dout_sel), .l_k_0(l_k_0), .done(done));

  always #5 clk = ~clk;

  task automatic clear_pats();
    for (int t = 0; t < N; t++) begin stall_in[t] = 0; start_pat[t] = 0; rst_pat[t] = 0; end
  endtask

  // Beat k goes out in the k-th unstalled slot from cycle 1 and returns RD cycles later.
  task automatic build_model(input logic [SW-1:0] sel, input logic [AW-1:0] base, input int len,
                             input bit dec, input bit lk, output int ncyc);
    bit            ena_e [N];
    logic [AW-1:0] iaddr [N];
    logic [SW-1:0] sel_e [N];
    logic [CW-1:0] cnt_e [N];
    bit            lk_e [N], done_e [N], ready_e [N];
    logic [AW-1:0] a;
    int t, last_out;
    for (int u = 0; u < N; u++) begin
      ena_e[u] = 0; iaddr[u] = '0; sel_e[u] = '0; cnt_e[u] = '0;
      lk_e[u] = 0; done_e[u] = 0; ready_e[u] = 1;
    end
    if (len == 0) begin
      done_e[1] = 1; ready_e[1] = 0; ncyc = 4;
    end else begin
      t = 1;
      for (int k = 0; k < len; k++) begin
        if (k > 0) begin
          t++;
          while (t < N - RD - 4 && stall_in[t]) t++;
        end
        ena_e[t] = 1;
        iaddr[t] = dec ? base - AW'(k) : base + AW'(k);
        sel_e[t+RD] = sel; cnt_e[t+RD] = CW'(k); lk_e[t+RD] = lk;
      end
      last_out = t + RD;
      done_e[last_out] = 1;
      for (int u = 1; u <= last_out; u++) ready_e[u] = 0;
      ncyc = last_out + 3;
    end
    a = model_addr;
    for (int u = 0; u < N; u++) begin
      if (ena_e[u]) a = iaddr[u];
      exp_vec[u] = {ena_e[u], a, sel_e[u], cnt_e[u], lk_e[u], done_e[u], ready_e[u]};
    end
    model_addr = a;
  endtask

  // Starts in cycle 0 (just after an edge); cmd_* are scrambled after the accept.
  task automatic run_trace(input logic [SW-1:0] sel, input logic [AW-1:0] base, input int len,
                           input bit dec, input bit lk, input int ncyc);
    cmd_sel = sel; cmd_base = base; cmd_len = CW'(len); cmd_dec = dec; cmd_l_k_0 = lk;
    for (int t = 0; t < ncyc; t++) begin
      start = (t == 0) || start_pat[t];
      if (t > 0) begin
        cmd_sel = SW'($urandom); cmd_base = AW'($urandom); cmd_len = CW'($urandom_range(1, 20));
        cmd_dec = 1'($urandom); cmd_l_k_0 = 1'($urandom);
      end
      stall = stall_in[t+1];
      sys_rst = rst_pat[t];
      @(negedge clk);
      obs_vec[t] = {CB_ena, CB_addra, CB_douta_sel, seq_cnt_dout_sel, l_k_0, done, ready};
      @(posedge clk); #1;
    end
    start = 0; stall = 0; sys_rst = 0;
  endtask

  task automatic test_reset();
    sys_rst = 1;
    repeat (2) @(posedge clk);
    #1 sys_rst = 0;
    @(negedge clk);
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", ready); end
    checks++; if (CB_ena !== 1'b0) begin errors++; $display("FAIL reset_ena got %b exp 0", CB_ena); end
    checks++; if (CB_addra !== '0) begin errors++; $display("FAIL reset_addr got %h exp 0", CB_addra); end
    checks++; if (CB_douta_sel !== '0 || seq_cnt_dout_sel !== '0 || l_k_0 !== 1'b0) begin
      errors++; $display("FAIL reset_dout got %h/%h/%b exp 0/0/0", CB_douta_sel, seq_cnt_dout_sel, l_k_0);
    end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done); end
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    int n;
    clear_pats();
    build_model(5'b00101, 10'h010, 4, 0, 1, n);
    run_trace(5'b00101, 10'h010, 4, 0, 1, n);
    for (int t = 0; t < n; t++) begin
      checks++;
      if (obs_vec[t] !== exp_vec[t]) begin errors++; $display("FAIL basic cyc %0d got %h exp %h", t, obs_vec[t], exp_vec[t]); end
    end
    checks++; if (obs_vec[6][1] !== 1'b1) begin errors++; $display("FAIL basic_done6 got %b exp 1", obs_vec[6][1]); end
    checks++; if (obs_vec[7][0] !== 1'b1) begin errors++; $display("FAIL basic_ready7 got %b exp 1", obs_vec[7][0]); end
    checks++; if (obs_vec[3][17:13] !== 5'b00101) begin errors++; $display("FAIL basic_sel3 got %b exp 00101", obs_vec[3][17:13]); end
  endtask

  task automatic test_dec_wrap();
    int n;
    logic [AW-1:0] want [3];
    want[0] = 10'h001; want[1] = 10'h000; want[2] = 10'h3FF;
    clear_pats();
    build_model(5'b01010, 10'h001, 3, 1, 1, n);
    run_trace(5'b01010, 10'h001, 3, 1, 1, n);
    for (int t = 0; t < n; t++) begin
      checks++;
      if (obs_vec[t] !== exp_vec[t]) begin errors++; $display("FAIL dec_wrap cyc %0d got %h exp %h", t, obs_vec[t], exp_vec[t]); end
    end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (obs_vec[k+1][27:18] !== want[k]) begin errors++; $display("FAIL dec_addr beat %0d got %h exp %h", k, obs_vec[k+1][27:18], want[k]); end
    end
  endtask

  task automatic test_new_sel();
    int n;
    clear_pats();
    build_model(5'b10011, AW'($urandom), 5, 0, 0, n);
    run_trace(5'b10011, exp_vec[1][27:18], 5, 0, 0, n);
    for (int t = 0; t < n; t++) begin
      checks++;
      if (obs_vec[t] !== exp_vec[t]) begin errors++; $display("FAIL new_sel cyc %0d got %h exp %h", t, obs_vec[t], exp_vec[t]); end
    end
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (obs_vec[3+k][12:3] !== CW'(k)) begin errors++; $display("FAIL new_cnt beat %0d got %0d exp %0d", k, obs_vec[3+k][12:3], k); end
    end
  endtask

  task automatic test_stall();
    int n;
    logic [5:0] ena_obs;
    clear_pats();
    stall_in[2] = 1; stall_in[3] = 1;
    build_model(5'b00110, 10'h100, 4, 0, 1, n);
    run_trace(5'b00110, 10'h100, 4, 0, 1, n);
    for (int t = 0; t < n; t++) begin
      checks++;
      if (obs_vec[t] !== exp_vec[t]) begin errors++; $display("FAIL stall cyc %0d got %h exp %h", t, obs_vec[t], exp_vec[t]); end
    end
    for (int t = 1; t <= 6; t++) ena_obs[t-1] = obs_vec[t][VW-1];
    checks++; if (ena_obs !== 6'b111001) begin errors++; $display("FAIL stall_ena cyc6..1 got %b exp 111001", ena_obs); end
    checks++; if (obs_vec[8][1] !== 1'b1) begin errors++; $display("FAIL stall_done8 got %b exp 1", obs_vec[8][1]); end
  endtask

  task automatic test_len0();
    int n;
    clear_pats();
    build_model(5'b11111, 10'h2AA, 0, 0, 1, n);
    run_trace(5'b11111, 10'h2AA, 0, 0, 1, n);
    for (int t = 0; t < n; t++) begin
      checks++;
      if (obs_vec[t] !== exp_vec[t]) begin errors++; $display("FAIL len0 cyc %0d got %h exp %h", t, obs_vec[t], exp_vec[t]); end
    end
    checks++; if (obs_vec[1][1] !== 1'b1) begin errors++; $display("FAIL len0_done1 got %b exp 1", obs_vec[1][1]); end
    checks++; if (obs_vec[2][0] !== 1'b1) begin errors++; $display("FAIL len0_ready2 got %b exp 1", obs_vec[2][0]); end
  endtask

  task automatic test_random();
    int n, len;
    logic [SW-1:0] sel;
    logic [AW-1:0] base;
    bit dec, lk;
    for (int it = 0; it < 25; it++) begin
      clear_pats();
      for (int t = 2; t < 40; t++) stall_in[t] = ($urandom_range(0, 9) < 3);
      sel = SW'($urandom); base = AW'($urandom); dec = 1'($urandom); lk = 1'($urandom);
      len = (it % 8 == 7) ? 0 : $urandom_range(1, 12);
      build_model(sel, base, len, dec, lk, n);
      run_trace(sel, base, len, dec, lk, n);
      for (int t = 0; t < n; t++) begin
        checks++;
        if (obs_vec[t] !== exp_vec[t]) begin
          errors++; $display("FAIL random it %0d len %0d cyc %0d got %h exp %h", it, len, t, obs_vec[t], exp_vec[t]);
        end
      end
    end
  endtask

  task automatic test_robust();
    int n;
    clear_pats();
    start_pat[3] = 1;
    rst_pat[4] = 1;
    build_model(5'b00101, 10'h3FD, 6, 0, 1, n);
    run_trace(5'b00101, 10'h3FD, 6, 0, 1, 14);
    model_addr = '0;
    for (int t = 0; t <= 4; t++) begin
      checks++;
      if (obs_vec[t] !== exp_vec[t]) begin errors++; $display("FAIL robust_pre cyc %0d got %h exp %h", t, obs_vec[t], exp_vec[t]); end
    end
    for (int t = 5; t < 14; t++) begin
      checks++;
      if (obs_vec[t] !== VW'(1)) begin errors++; $display("FAIL robust_post cyc %0d got %h exp %h", t, obs_vec[t], VW'(1)); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_dec_wrap();
    test_new_sel();
    test_stall();
    test_len0();
    test_random();
    test_robust();
    test_basic();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/cb_rd_seq.md
Name: cb_rd_seq

Overview:
- Read sequencer for covariance-bank (CB) port A.
- Accepts one read command: destination, direction, base address, length and landmark parity.
- Issues CB_ena/CB_addra for `len` consecutive rows.
- Emits CB_douta_sel, seq_cnt_dout_sel and l_k_0 delayed by the bank read latency, so the downstream douta mapping stage receives select and data in the same cycle.
- Sits between the top-level step controller and the CB douta mapping stage.

Parameters:
CB_AW, 10, CB port A address width
SEQ_CNT_DW, 10, width of the read count and of seq_cnt_dout_sel
CB_DOUTA_SEL_DW, 5, select width: [4:2] destination, [1:0] direction
RD_LAT, 2, cycles from CB_ena/CB_addra to valid CB_douta (>=1)

Ports:
clk  in  1  clock
sys_rst  in  1  synchronous active-high reset
start  in  1  command strobe, accepted only when ready=1
cmd_sel  in  CB_DOUTA_SEL_DW  destination/direction code, forwarded unchanged per beat
cmd_base  in  CB_AW  first read address
cmd_len  in  SEQ_CNT_DW  number of reads; 0 = no-op
cmd_dec  in  1  1 = address decrements per beat, 0 = increments
cmd_l_k_0  in  1  landmark parity bit for NEW mappings
stall  in  1  holds read issue for the current cycle
ready  out  1  idle, can accept a command
CB_ena  out  1  port A read enable
CB_addra  out  CB_AW  port A read address
CB_douta_sel  out  CB_DOUTA_SEL_DW  select aligned with returned data
seq_cnt_dout_sel  out  SEQ_CNT_DW  beat index aligned with returned data
l_k_0  out  1  latched parity aligned with returned data
done  out  1  one-cycle pulse, command complete

Behaviour:
- All outputs are registered.
- Reset values: ready=1, all other outputs 0, state=IDLE, delay line cleared.
- States and transitions:
  - IDLE: ready=1. On start=1, latch sel/base/dec/l_k_0/len and clear the beat counter cnt. Go to ISSUE if len!=0; otherwise go to DONE0.
  - DONE0: done=1 for one cycle, no reads, then IDLE.
  - ISSUE: ready=0.
    - Each cycle with stall=0: CB_ena=1; CB_addra = base+cnt (dec=0) or base-cnt (dec=1), modulo 2^CB_AW (wrap-around is legal); push {valid=1, sel, cnt, l_k_0} into the delay line; cnt++.
    - When cnt reaches len-1 and is issued, go to DRAIN.
    - With stall=1: CB_ena=0, CB_addra holds, cnt holds, and a bubble (valid=0) is pushed.
  - DRAIN: CB_ena=0; bubbles are pushed until the last valid entry exits, then IDLE.
- Delay line: RD_LAT stages, shifts every cycle regardless of stall.
  - Output valid entry: CB_douta_sel=sel, seq_cnt_dout_sel=cnt, l_k_0=l_k_0.
  - Output bubble: all three outputs are 0 (sel 0 = IDLE).
- Timing with no stalls, start accepted in cycle c:
  - Reads are issued in cycles c+1 .. c+len.
  - Beat k select appears in cycle c+1+k+RD_LAT.
  - done=1 in the same cycle as the last valid select.
  - ready=1 again from the following cycle.
- start while ready=0 is ignored; no queuing.
- cmd_* inputs are sampled only on acceptance; later changes have no effect.
- sys_rst mid-command: next edge returns to the reset state, in-flight beats are discarded, no done pulse.
- stall in IDLE or DRAIN has no effect.

Test Plan:
- RD_LAT=2; start cycle 0; sel=5'b00101 (A,POS), base=0x010, len=4, dec=0:
  - CB_ena=1 in cycles 1-4 with addr 0x010..0x013.
  - CB_douta_sel=5'b00101 in cycles 3-6 with seq_cnt 0,1,2,3.
  - done in cycle 6; ready=1 in cycle 7.
- Decrement wrap: base=0x001, len=3, dec=1 -> addrs 0x001, 0x000, 0x3FF.
- sel=5'b10011 (TBa,NEW), l_k_0=0, len=5:
  - seq_cnt_dout_sel 0..4 on consecutive cycles with sel=5'b10011 and l_k_0=0.
  - Outputs 0 before and after the burst.
- len=4, stall=1 in cycles 2-3:
  - Addrs issued in cycles 1, 4, 5, 6.
  - Output sel holes (0) in cycles 4-5.
  - done in cycle 8.
- len=0 -> done in cycle 1, CB_ena never 1, ready=1 in cycle 2.
- Robustness, len=6:
  - A second start in cycle 3 is ignored: address sequence unchanged.
  - sys_rst in cycle 4: cycle 5 shows CB_ena=0, sel=0, ready=1, and done is never pulsed.
